// File: rtl/amo_unit.sv
// -----------------------------------------------------------------------------
// amo_unit
//   Atomic-memory execution stage between the memory-access stage and the
//   data cache. Non-atomic requests pass straight through combinationally.
//   Atomic requests (LR / SC / AMO*) are expanded into a read, a conditional
//   write, or a read-modify-write toward the dcache. The LR/SC reservation
//   set is owned here.
//
//   Optional feature macro: AMO_RESV_SNOOP_EN
//     defined   : a passthrough store that hits the reserved doubleword clears
//                 the reservation in the cycle of its data_ok.
//     undefined : reservation cleared only by SC, clear_resv, or reset.
//
//   Ports
//     clk        in   clock
//     reset      in   asynchronous reset, active low
//     dreq_i     in   request from the memory stage (held until data_ok)
//     dresp_o    out  response to the memory stage
//     dreq_o     out  request to the dcache (is_atomic always 0)
//     dresp_i    in   response from the dcache
//     clear_resv in   trap/xret taken, invalidates the reservation
//     resv_o     out  current reservation (debug / difftest)
// -----------------------------------------------------------------------------
package common;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [2:0]  msize_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [4:0]  amo_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  localparam amo_t AMO_ADD  = 5'd0;
  localparam amo_t AMO_SWAP = 5'd1;
  localparam amo_t AMO_LR   = 5'd2;
  localparam amo_t AMO_SC   = 5'd3;
  localparam amo_t AMO_XOR  = 5'd4;
  localparam amo_t AMO_AND  = 5'd5;
  localparam amo_t AMO_OR   = 5'd6;
  localparam amo_t AMO_MIN  = 5'd7;
  localparam amo_t AMO_MAX  = 5'd8;
  localparam amo_t AMO_MINU = 5'd9;
  localparam amo_t AMO_MAXU = 5'd10;

  // 1 + 1 + 5 + 64 + 3 + 8 + 64 = 146 bits
  typedef struct packed {
    logic    valid;
    logic    is_atomic;
    amo_t    atomic_op;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  // 1 + 1 + 64 = 66 bits
  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } reservation_t;
endpackage

module amo_unit
  import common::*;
(
  input  logic         clk,
  input  logic         reset,
  input  dbus_req_t    dreq_i,
  output dbus_resp_t   dresp_o,
  output dbus_req_t    dreq_o,
  input  dbus_resp_t   dresp_i,
  input  logic         clear_resv,
  output reservation_t resv_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]   state_q, state_d;
  reservation_t resv_q, resv_d;
  amo_t         op_q, op_d;
  addr_t        addr_q, addr_d;
  msize_t       size_q, size_d;
  word_t        data_q, data_d;
  word_t        wdata_q, wdata_d;
  word_t        result_q, result_d;
  logic         sc_ok;
  logic         snoop_hit;

  function automatic logic [31:0] alu32(input amo_t op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    case (op)
      AMO_ADD:  r = a + b;
      AMO_SWAP: r = b;
      AMO_XOR:  r = a ^ b;
      AMO_AND:  r = a & b;
      AMO_OR:   r = a | b;
      AMO_MIN:  r = (sa < sb) ? a : b;
      AMO_MAX:  r = (sa > sb) ? a : b;
      AMO_MINU: r = (a < b) ? a : b;
      AMO_MAXU: r = (a > b) ? a : b;
      default:  r = a;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] alu64(input amo_t op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        r;
    sa = a;
    sb = b;
    case (op)
      AMO_ADD:  r = a + b;
      AMO_SWAP: r = b;
      AMO_XOR:  r = a ^ b;
      AMO_AND:  r = a & b;
      AMO_OR:   r = a | b;
      AMO_MIN:  r = (sa < sb) ? a : b;
      AMO_MAX:  r = (sa > sb) ? a : b;
      AMO_MINU: r = (a < b) ? a : b;
      AMO_MAXU: r = (a > b) ? a : b;
      default:  r = a;
    endcase
    return r;
  endfunction

  // Atomics are only word or doubleword; anything not MSIZE8 is a 32-bit lane.
  function automatic strobe_t lane_strobe(input msize_t size, input logic a2);
    if (size == MSIZE8) return 8'hFF;
    return a2 ? 8'hF0 : 8'h0F;
  endfunction

  // Keep only the addressed lane of w, zero elsewhere.
  function automatic word_t lane_place(input msize_t size, input logic a2,
                                       input word_t w);
    if (size == MSIZE8) return w;
    return a2 ? {w[63:32], 32'h0} : {32'h0, w[31:0]};
  endfunction

  function automatic word_t sc_word(input msize_t size, input logic a2,
                                    input logic fail);
    if (size == MSIZE8) return {63'h0, fail};
    return a2 ? {31'h0, fail, 32'h0} : {63'h0, fail};
  endfunction

  function automatic word_t amo_compute(input amo_t op, input msize_t size,
                                        input logic a2, input word_t old,
                                        input word_t operand);
    if (size == MSIZE8) return alu64(op, old, operand);
    if (a2) return {alu32(op, old[63:32], operand[63:32]), 32'h0};
    return {32'h0, alu32(op, old[31:0], operand[31:0])};
  endfunction

`ifdef AMO_RESV_SNOOP_EN
  assign snoop_hit = (state_q == S_IDLE) && dreq_i.valid && !dreq_i.is_atomic &&
                     (dreq_i.strobe != 8'h00) &&
                     (dreq_i.addr[63:3] == resv_q.addr[63:3]) && dresp_i.data_ok;
`else
  assign snoop_hit = 1'b0;
`endif

  // clear_resv in the same cycle kills an SC even if the address matches
  assign sc_ok = resv_q.valid && (resv_q.addr == dreq_i.addr) && !clear_resv;

  always_comb begin
    state_d  = state_q;
    resv_d   = resv_q;
    op_d     = op_q;
    addr_d   = addr_q;
    size_d   = size_q;
    data_d   = data_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    dreq_o   = '0;
    dresp_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (dreq_i.valid && dreq_i.is_atomic) begin
          op_d   = dreq_i.atomic_op;
          addr_d = dreq_i.addr;
          size_d = dreq_i.size;
          data_d = dreq_i.data;
          if (dreq_i.atomic_op == AMO_SC) begin
            // Either outcome consumes the reservation.
            resv_d.valid = 1'b0;
            if (sc_ok) begin
              state_d  = S_WR;
              wdata_d  = lane_place(dreq_i.size, dreq_i.addr[2], dreq_i.data);
              result_d = sc_word(dreq_i.size, dreq_i.addr[2], 1'b0);
            end else begin
              state_d  = S_RESP;
              result_d = sc_word(dreq_i.size, dreq_i.addr[2], 1'b1);
            end
          end else begin
            state_d = S_RD;
          end
        end else begin
          dreq_o           = dreq_i;
          dreq_o.is_atomic = 1'b0;
          dresp_o          = dresp_i;
        end
      end

      S_RD: begin
        dreq_o.valid = 1'b1;
        dreq_o.addr  = addr_q;
        dreq_o.size  = size_q;
        if (dresp_i.data_ok) begin
          result_d = dresp_i.data;
          if (op_q == AMO_LR) begin
            resv_d  = '{valid: 1'b1, addr: addr_q};
            state_d = S_RESP;
          end else begin
            wdata_d = amo_compute(op_q, size_q, addr_q[2], dresp_i.data, data_q);
            state_d = S_WR;
          end
        end
      end

      S_WR: begin
        dreq_o.valid  = 1'b1;
        dreq_o.addr   = addr_q;
        dreq_o.size   = size_q;
        dreq_o.strobe = lane_strobe(size_q, addr_q[2]);
        dreq_o.data   = wdata_q;
        if (dresp_i.data_ok) state_d = S_RESP;
      end

      S_RESP: begin
        dresp_o.addr_ok = 1'b1;
        dresp_o.data_ok = 1'b1;
        dresp_o.data    = result_q;
        state_d         = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Applied last so it overrides an LR setting the reservation this cycle.
    if (clear_resv || snoop_hit) resv_d.valid = 1'b0;
  end

  // control state: reset asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      resv_q  <= '0;
    end else begin
      state_q <= state_d;
      resv_q  <= resv_d;
    end
  end

  // datapath registers: only meaningful once the FSM has loaded them
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    addr_q   <= addr_d;
    size_q   <= size_d;
    data_q   <= data_d;
    wdata_q  <= wdata_d;
    result_q <= result_d;
  end

  assign resv_o = resv_q;

endmodule

// File: tb/tb_amo_unit.sv
module tb_amo_unit;
  import common::*;

  logic         clk;
  logic         reset;
  dbus_req_t    dreq_i;
  dbus_resp_t   dresp_o;
  dbus_req_t    dreq_o;
  dbus_resp_t   dresp_i;
  logic         clear_resv;
  reservation_t resv_o;

  amo_unit dut (
    .clk        (clk),
    .reset      (reset),
    .dreq_i     (dreq_i),
    .dresp_o    (dresp_o),
    .dreq_o     (dreq_o),
    .dresp_i    (dresp_i),
    .clear_resv (clear_resv),
    .resv_o     (resv_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // dcache model
  word_t       mem [0:2047];
  int          lat_r = 1;
  int          lat_w = 1;
  int          cnt   = 0;
  int          lat_cur;
  int          n_rd  = 0;
  int          n_wr  = 0;
  word_t       wr_data;
  strobe_t     wr_strb;
  addr_t       wr_addr;
  logic [10:0] idx;
  logic        pl_do = 1'b0;
  logic [10:0] pl_idx;
  word_t       pl_val;
  logic        clr_manual = 1'b0;
  logic        clr_on_dok = 1'b0;

  assign idx     = dreq_o.addr[13:3];
  assign lat_cur = (dreq_o.strobe != 8'h00) ? lat_w : lat_r;
  assign clear_resv = clr_manual | (clr_on_dok & dreq_o.valid & dresp_i.data_ok);

  always_comb begin
    dresp_i = '0;
    if (dreq_o.valid && (cnt >= lat_cur - 1)) begin
      dresp_i.addr_ok = 1'b1;
      dresp_i.data_ok = 1'b1;
      dresp_i.data    = mem[idx];
    end
  end

  always @(posedge clk) begin
    if (pl_do) mem[pl_idx] <= pl_val;
    if (dreq_o.valid && dresp_i.data_ok) begin
      cnt <= 0;
      if (dreq_o.strobe != 8'h00) begin
        for (int i = 0; i < 8; i++)
          if (dreq_o.strobe[i]) mem[idx][8*i +: 8] <= dreq_o.data[8*i +: 8];
        n_wr    <= n_wr + 1;
        wr_data <= dreq_o.data;
        wr_strb <= dreq_o.strobe;
        wr_addr <= dreq_o.addr;
      end else begin
        n_rd <= n_rd + 1;
      end
    end else if (dreq_o.valid) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic word_t strb_mask(input strobe_t s);
    word_t m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic preload(input addr_t a, input word_t v);
    pl_idx = a[13:3];
    pl_val = v;
    pl_do  = 1'b1;
    @(posedge clk); #1;
    pl_do  = 1'b0;
  endtask

  function automatic dbus_req_t mk_req(input logic atomic, input amo_t op, input addr_t a,
                                       input msize_t sz, input strobe_t st, input word_t d);
    dbus_req_t r;
    r           = '0;
    r.valid     = 1'b1;
    r.is_atomic = atomic;
    r.atomic_op = op;
    r.addr      = a;
    r.size      = sz;
    r.strobe    = st;
    r.data      = d;
    return r;
  endfunction

  // Called and returns at posedge+1. Counts cycles up to and including data_ok.
  task automatic run_req(input dbus_req_t r, output word_t d, output int cyc);
    bit done;
    done   = 1'b0;
    cyc    = 0;
    d      = '0;
    dreq_i = r;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (dreq_o.valid && dreq_o.is_atomic) begin
        n_fail++;
        $display("FAIL down_is_atomic: got 1 expected 0");
      end
      if (dresp_o.data_ok) begin
        d    = dresp_o.data;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    dreq_i = '0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: got no data_ok expected data_ok within 60 cycles");
    end
  endtask

  typedef struct {
    string   name;
    logic    atomic;
    amo_t    op;
    addr_t   addr;
    msize_t  size;
    word_t   data;
    word_t   mem;
    int      lr;
    int      lw;
    word_t   exp_resp;
    int      exp_cyc;
    logic    exp_wr;
    strobe_t exp_strb;
    word_t   exp_wdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    word_t d;
    int    cyc;
    int    wr0;
    int    req0;
    word_t m;

    vecs[0] = '{"amoadd_d", 1'b1, AMO_ADD, 64'h80001000, MSIZE8, 64'd7, 64'd5,
                2, 2, 64'd5, 6, 1'b1, 8'hFF, 64'd12};
    vecs[1] = '{"amomin_w_sign", 1'b1, AMO_MIN, 64'h80001000, MSIZE4, 64'h00000003_00000003,
                64'h12345678_FFFFFFFF, 1, 1, 64'h12345678_FFFFFFFF, 4, 1'b1, 8'h0F,
                64'h00000000_FFFFFFFF};
    vecs[2] = '{"amominu_w", 1'b1, AMO_MINU, 64'h80001000, MSIZE4, 64'h00000003_00000003,
                64'h12345678_FFFFFFFF, 1, 1, 64'h12345678_FFFFFFFF, 4, 1'b1, 8'h0F,
                64'h00000000_00000003};
    vecs[3] = '{"amomax_w_hi", 1'b1, AMO_MAX, 64'h80001004, MSIZE4, 64'h00000007_00000007,
                64'h80000000_00000005, 3, 1, 64'h80000000_00000005, 6, 1'b1, 8'hF0,
                64'h00000007_00000000};
    vecs[4] = '{"amoswap_d", 1'b1, AMO_SWAP, 64'h80001000, MSIZE8, 64'hDEADBEEF_CAFEF00D,
                64'h1111, 1, 3, 64'h1111, 6, 1'b1, 8'hFF, 64'hDEADBEEF_CAFEF00D};
    vecs[5] = '{"amoadd_w_wrap", 1'b1, AMO_ADD, 64'h80001000, MSIZE4, 64'h00000002_00000002,
                64'hAAAAAAAA_FFFFFFFF, 2, 1, 64'hAAAAAAAA_FFFFFFFF, 5, 1'b1, 8'h0F,
                64'h00000000_00000001};
    vecs[6] = '{"amomaxu_w_hi", 1'b1, AMO_MAXU, 64'h80001004, MSIZE4, 64'h00000007_00000007,
                64'h80000000_00000000, 1, 1, 64'h80000000_00000000, 4, 1'b1, 8'hF0,
                64'h80000000_00000000};
    vecs[7] = '{"amoand_d", 1'b1, AMO_AND, 64'h80001000, MSIZE8, 64'hFF00FF00_FF00FF00,
                64'hF0F0F0F0_F0F0F0F0, 1, 2, 64'hF0F0F0F0_F0F0F0F0, 5, 1'b1, 8'hFF,
                64'hF000F000_F000F000};
    vecs[8] = '{"pass_load", 1'b0, AMO_ADD, 64'h80001008, MSIZE8, 64'd0, 64'h55,
                2, 1, 64'h55, 2, 1'b0, 8'h00, 64'd0};
    vecs[9] = '{"amomax_d_sign", 1'b1, AMO_MAX, 64'h80001000, MSIZE8, 64'd1,
                64'hFFFFFFFF_FFFFFFFE, 1, 1, 64'hFFFFFFFF_FFFFFFFE, 4, 1'b1, 8'hFF, 64'd1};

    reset  = 1'b0;
    dreq_i = '0;
    #12;
    chk("reset_dreq_o", dreq_o, '0);
    chk("reset_dresp_o", dresp_o, '0);
    chk("reset_resv_o", resv_o, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].addr, vecs[i].mem);
      lat_r = vecs[i].lr;
      lat_w = vecs[i].lw;
      wr0   = n_wr;
      run_req(mk_req(vecs[i].atomic, vecs[i].op, vecs[i].addr, vecs[i].size, 8'h00,
                     vecs[i].data), d, cyc);
      chk({vecs[i].name, "_resp"}, d, vecs[i].exp_resp);
      chk({vecs[i].name, "_cycles"}, 64'(cyc), 64'(vecs[i].exp_cyc));
      chk({vecs[i].name, "_nwrites"}, 64'(n_wr - wr0), {63'h0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) begin
        m = strb_mask(vecs[i].exp_strb);
        chk({vecs[i].name, "_strobe"}, 64'(wr_strb), 64'(vecs[i].exp_strb));
        chk({vecs[i].name, "_wdata"}, wr_data & m, vecs[i].exp_wdata & m);
        chk({vecs[i].name, "_waddr"}, wr_addr, vecs[i].addr);
      end
    end

    // LR.W then SC.W succeeds, then a second SC.W fails without touching memory
    preload(64'h80001000, 64'h01234567_89ABCDEF);
    lat_r = 2; lat_w = 2;
    run_req(mk_req(1'b1, AMO_LR, 64'h80001004, MSIZE4, 8'h00, 64'd0), d, cyc);
    chk("lr_w_resp", d, 64'h01234567_89ABCDEF);
    chk("lr_w_cycles", 64'(cyc), 64'd4);
    chk("lr_w_resv", resv_o, {1'b1, 64'h80001004});
    wr0 = n_wr;
    run_req(mk_req(1'b1, AMO_SC, 64'h80001004, MSIZE4, 8'h00, 64'h0000ABCD_0000ABCD), d, cyc);
    chk("sc_w_ok_resp", d, 64'd0);
    chk("sc_w_ok_cycles", 64'(cyc), 64'd4);
    chk("sc_w_ok_nwrites", 64'(n_wr - wr0), 64'd1);
    chk("sc_w_ok_strobe", 64'(wr_strb), 64'hF0);
    chk("sc_w_ok_wdata_hi", 64'(wr_data[63:32]), 64'h0000ABCD);
    chk("sc_w_ok_resv_valid", 64'(resv_o.valid), 64'd0);
    req0 = n_rd + n_wr;
    run_req(mk_req(1'b1, AMO_SC, 64'h80001004, MSIZE4, 8'h00, 64'h0000ABCD_0000ABCD), d, cyc);
    chk("sc_w_fail_resp", d, 64'h00000001_00000000);
    chk("sc_w_fail_cycles", 64'(cyc), 64'd2);
    chk("sc_w_fail_no_dcache", 64'(n_rd + n_wr - req0), 64'd0);

    // LR.D, clear_resv pulse in idle, SC.D fails
    lat_r = 1; lat_w = 1;
    run_req(mk_req(1'b1, AMO_LR, 64'h80001000, MSIZE8, 8'h00, 64'd0), d, cyc);
    chk("lr_d_resv_valid", 64'(resv_o.valid), 64'd1);
    clr_manual = 1'b1;
    @(posedge clk); #1;
    clr_manual = 1'b0;
    chk("clear_pulse_resv_valid", 64'(resv_o.valid), 64'd0);
    run_req(mk_req(1'b1, AMO_SC, 64'h80001000, MSIZE8, 8'h00, 64'd9), d, cyc);
    chk("sc_d_after_clear_resp", d, 64'd1);
    chk("sc_d_after_clear_cycles", 64'(cyc), 64'd2);

    // clear_resv coincides with LR data_ok: clear wins
    lat_r = 2;
    clr_on_dok = 1'b1;
    run_req(mk_req(1'b1, AMO_LR, 64'h80001000, MSIZE8, 8'h00, 64'd0), d, cyc);
    clr_on_dok = 1'b0;
    chk("lr_clear_same_cycle_resv_valid", 64'(resv_o.valid), 64'd0);

    // snoop: passthrough byte store into the reserved doubleword
    lat_r = 1; lat_w = 1;
    run_req(mk_req(1'b1, AMO_LR, 64'h80002000, MSIZE8, 8'h00, 64'd0), d, cyc);
    chk("snoop_lr_resv_valid", 64'(resv_o.valid), 64'd1);
    run_req(mk_req(1'b0, AMO_ADD, 64'h80002003, MSIZE1, 8'h08, 64'h00000000_77000000), d, cyc);
    chk("snoop_sb_cycles", 64'(cyc), 64'd1);
    run_req(mk_req(1'b1, AMO_SC, 64'h80002000, MSIZE8, 8'h00, 64'h99), d, cyc);
`ifdef AMO_RESV_SNOOP_EN
    chk("snoop_sc_resp", d, 64'd1);
    chk("snoop_sc_cycles", 64'(cyc), 64'd2);
`else
    chk("snoop_sc_resp", d, 64'd0);
    chk("snoop_sc_cycles", 64'(cyc), 64'd3);
`endif

    // reset asserted during AMOSWAP's read phase
    run_req(mk_req(1'b1, AMO_LR, 64'h80001000, MSIZE8, 8'h00, 64'd0), d, cyc);
    chk("rst_pre_resv_valid", 64'(resv_o.valid), 64'd1);
    lat_r = 5;
    dreq_i = mk_req(1'b1, AMO_SWAP, 64'h80001000, MSIZE8, 8'h00, 64'h5A5A);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rd_valid", 64'(dreq_o.valid), 64'd1);
    chk("rst_rd_strobe", 64'(dreq_o.strobe), 64'd0);
    chk("rst_rd_addr", dreq_o.addr, 64'h80001000);
    wr0 = n_wr;
    #2 reset = 1'b0;
    #1;
    chk("rst_async_valid", 64'(dreq_o.valid), 64'd0);
    chk("rst_async_resv", resv_o, '0);
    chk("rst_async_dresp", dresp_o, '0);
    dreq_i = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_write", 64'(n_wr - wr0), 64'd0);
    chk("rst_idle_dreq_o", dreq_o, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
